cordic_seq_ctrl: RTL and testbench

CORDIC_SEQ_CTRL -- requirements
Module: cordic_seq_ctrl

---
 rtl/cordic_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_cordic_seq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cordic_seq_ctrl
//
// Sequencer for an iterative CORDIC datapath. A start request loads the
// initial operands. The datapath is then clocked through N_ITER
// micro-rotations, and the result is flagged as valid. A running operation
// can be cancelled.
//
// Parameters
//   N_ITER   : micro-rotations per operation (2..64)
//   ITR_W    : width of the iteration index (2**ITR_W >= N_ITER)
//   AUTO_ACK : 1 -> fin is a one-cycle pulse; 0 -> fin is held until ack
//
// Ports
//   clk     : clock; all state changes on the rising edge
//   rst     : asynchronous active-high reset
//   bgn     : start request, accepted only in IDLE
//   mode_in : requested mode (0 rotation, 1 vectoring), captured with bgn
//   abort   : cancel request, honoured only in EXEC
//   ack     : result consumed, honoured only in DONE when AUTO_ACK=0
//   ld      : datapath register load enable
//   init    : datapath selects initial operands instead of iteration results
//   itr     : current iteration index (shift amount / atan LUT address)
//   mode    : mode latched for the running or finished operation
//   busy    : high in EXEC and DONE
//   fin     : result valid (DONE)
//   abrt    : one-cycle pulse after an operation was cancelled
// ---------------------------------------------------------------------------
module cordic_seq_ctrl #(
  parameter int N_ITER   = 16,
  parameter int ITR_W    = 4,
  parameter int AUTO_ACK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bgn,
  input  logic             mode_in,
  input  logic             abort,
  input  logic             ack,
  output logic             ld,
  output logic             init,
  output logic [ITR_W-1:0] itr,
  output logic             mode,
  output logic             busy,
  output logic             fin,
  output logic             abrt
);

  // Reject illegal parameter combinations at elaboration time.
  generate
    if ((N_ITER < 2) || (N_ITER > 64) || ((64'd1 << ITR_W) < 64'(N_ITER))) begin : g_bad_param
      $error("cordic_seq_ctrl: illegal N_ITER/ITR_W combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ITR_W-1:0] LAST_ITR = ITR_W'(N_ITER - 1);

  state_t state;
  state_t state_next;

  // Next-state decode. The unused encoding falls back to IDLE.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: state_next = bgn ? EXEC : IDLE;
      EXEC: begin
        if (abort)
          state_next = IDLE;
        else if (itr == LAST_ITR)
          state_next = DONE;
        else
          state_next = EXEC;
      end
      DONE: state_next = ((AUTO_ACK != 0) || ack) ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end

  // ld/init must respond in the same cycle as bgn, so they are decoded
  // combinationally. They are gated by rst so that they drop as soon as
  // reset is asserted, even while bgn is still high.
  assign init = !rst && (state == IDLE) && bgn;
  assign ld   = !rst && (((state == IDLE) && bgn) || ((state == EXEC) && !abort));

  // busy and fin are registered from the next state. This keeps them
  // glitch-free and means they are not decoded from the state bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      itr   <= '0;
      mode  <= 1'b0;
      busy  <= 1'b0;
      fin   <= 1'b0;
      abrt  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      fin   <= (state_next == DONE);
      abrt  <= (state == EXEC) && abort;

      case (state)
        IDLE: begin
          itr <= '0;
          if (bgn)
            mode <= mode_in;
        end
        EXEC: begin
          // On abort or terminal count, itr wraps to 0. This makes itr
          // read 0 in IDLE and DONE.
          if (abort || (itr == LAST_ITR))
            itr <= '0;
          else
            itr <= itr + ITR_W'(1);
        end
        default: itr <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cordic_seq_ctrl
//
// Three instances share clk and rst:
//   a : N_ITER=16, ITR_W=4, AUTO_ACK=1
//   b : N_ITER=16, ITR_W=4, AUTO_ACK=0
//   c : N_ITER=5,  ITR_W=3, AUTO_ACK=1
// Inputs are driven just after the falling edge. Outputs are sampled 1 ns
// later. At that point ld/init reflect the inputs just driven, and the
// registered outputs reflect the state for the current cycle.
// Observed word = {ld, init, itr(6b), mode, busy, fin, abrt}.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cordic_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_bgn = 0, a_mode_in = 0, a_abort = 0, a_ack = 0;
  logic b_bgn = 0, b_mode_in = 0, b_abort = 0, b_ack = 0;
  logic c_bgn = 0, c_mode_in = 0, c_abort = 0, c_ack = 0;

  logic       a_ld, a_init, a_mode, a_busy, a_fin, a_abrt;
  logic [3:0] a_itr;
  logic       b_ld, b_init, b_mode, b_busy, b_fin, b_abrt;
  logic [3:0] b_itr;
  logic       c_ld, c_init, c_mode, c_busy, c_fin, c_abrt;
  logic [2:0] c_itr;

  cordic_seq_ctrl #(.N_ITER(16), .ITR_W(4), .AUTO_ACK(1)) dut_a (
    .clk(clk), .rst(rst), .bgn(a_bgn), .mode_in(a_mode_in), .abort(a_abort), .ack(a_ack),
    .ld(a_ld), .init(a_init), .itr(a_itr), .mode(a_mode), .busy(a_busy), .fin(a_fin), .abrt(a_abrt));

  cordic_seq_ctrl #(.N_ITER(16), .ITR_W(4), .AUTO_ACK(0)) dut_b (
    .clk(clk), .rst(rst), .bgn(b_bgn), .mode_in(b_mode_in), .abort(b_abort), .ack(b_ack),
    .ld(b_ld), .init(b_init), .itr(b_itr), .mode(b_mode), .busy(b_busy), .fin(b_fin), .abrt(b_abrt));

  cordic_seq_ctrl #(.N_ITER(5), .ITR_W(3), .AUTO_ACK(1)) dut_c (
    .clk(clk), .rst(rst), .bgn(c_bgn), .mode_in(c_mode_in), .abort(c_abort), .ack(c_ack),
    .ld(c_ld), .init(c_init), .itr(c_itr), .mode(c_mode), .busy(c_busy), .fin(c_fin), .abrt(c_abrt));

  wire [11:0] obs_a = {a_ld, a_init, 2'b00, a_itr, a_mode, a_busy, a_fin, a_abrt};
  wire [11:0] obs_b = {b_ld, b_init, 2'b00, b_itr, b_mode, b_busy, b_fin, b_abrt};
  wire [11:0] obs_c = {c_ld, c_init, 3'b000, c_itr, c_mode, c_busy, c_fin, c_abrt};

  typedef struct {
    logic        bgn;
    logic        mode_in;
    logic        abort;
    logic        ack;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [11:0] pk(input logic ld, input logic init, input int it,
                                     input logic md, input logic bz, input logic fn,
                                     input logic ab);
    logic [5:0] it6;
    it6 = 6'(it);
    return {ld, init, it6, md, bz, fn, ab};
  endfunction

  task automatic add(input logic b, input logic m, input logic a, input logic k,
                     input logic [11:0] e);
    vec_t v;
    v.bgn = b; v.mode_in = m; v.abort = a; v.ack = k; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (ld,init,itr,mode,busy,fin,abrt)", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  initial begin
    // ---------------- vector table for instance a ----------------
    // Full rotation-to-vectoring op, mode_in toggled and bgn pulsed mid-EXEC.
    add(1, 1, 0, 0, pk(1, 1, 0, 0, 0, 0, 0));
    for (int c = 1; c <= 16; c++)
      add(c == 5, 0, 0, 0, pk(1, 0, c - 1, 1, 1, 0, 0));
    add(0, 0, 1, 0, pk(0, 0, 0, 1, 1, 1, 0));          // DONE, abort ignored
    add(0, 0, 1, 1, pk(0, 0, 0, 1, 0, 0, 0));          // IDLE, abort/ack ignored
    // Abort at itr=7.
    add(1, 0, 0, 0, pk(1, 1, 0, 1, 0, 0, 0));
    for (int k = 0; k <= 6; k++)
      add(0, 1, 0, 0, pk(1, 0, k, 0, 1, 0, 0));
    add(0, 0, 1, 0, pk(0, 0, 7, 0, 1, 0, 0));          // abort: ld drops
    // abrt pulse coincides with a new bgn, which must still be accepted.
    add(1, 1, 0, 0, pk(1, 1, 0, 0, 0, 0, 1));
    // Abort on the terminal-count cycle.
    for (int k = 0; k <= 15; k++)
      add(0, 0, k == 15, 0, pk(k != 15, 0, k, 1, 1, 0, 0));
    add(0, 0, 0, 0, pk(0, 0, 0, 1, 0, 0, 1));
    add(0, 0, 0, 0, pk(0, 0, 0, 1, 0, 0, 0));

    // ---------------- reset state ----------------
    a_bgn = 1'b1;
    #2;
    chk("rst_a_outputs_zero", obs_a, 12'h000);
    chk("rst_c_outputs_zero", obs_c, 12'h000);
    a_bgn = 1'b0;

    // Release reset; the table's first bgn is accepted on the very next edge.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      a_bgn = vecs[i].bgn; a_mode_in = vecs[i].mode_in;
      a_abort = vecs[i].abort; a_ack = vecs[i].ack;
      #1;
      chk($sformatf("a_vec%0d", i), obs_a, vecs[i].exp);
      @(negedge clk);
    end
    a_bgn = 0; a_mode_in = 0; a_abort = 0; a_ack = 0;

    // ---------------- async reset mid-EXEC (instance a) ----------------
    a_bgn = 1'b1; a_mode_in = 1'b1;
    @(negedge clk);
    a_bgn = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("a_pre_rst_itr9", obs_a, pk(1, 0, 9, 1, 1, 0, 0));
    #1 rst = 1'b1;
    #1;
    chk("a_async_rst_zero", obs_a, 12'h000);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("a_after_rst_idle", obs_a, 12'h000);
    a_bgn = 1'b1; a_mode_in = 1'b0;
    #1;
    chk("a_restart_accept", obs_a, pk(1, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    a_bgn = 1'b0;
    #1;
    chk("a_restart_itr0", obs_a, pk(1, 0, 0, 0, 1, 0, 0));
    repeat (17) @(negedge clk);
    #1;
    chk("a_restart_complete_idle", obs_a, 12'h000);

    // ---------------- held fin / ack handshake (instance b) ----------------
    @(negedge clk);
    b_bgn = 1'b1; b_mode_in = 1'b1;
    #1;
    chk("b_accept", obs_b, pk(1, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    b_bgn = 1'b0;
    repeat (16) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("b_done_hold%0d", k), obs_b, pk(0, 0, 0, 1, 1, 1, 0));
      @(negedge clk);
    end
    b_ack = 1'b1; b_bgn = 1'b1;
    #1;
    chk("b_ack_with_bgn", obs_b, pk(0, 0, 0, 1, 1, 1, 0));
    @(negedge clk);
    b_ack = 1'b0; b_bgn = 1'b0;
    #1;
    chk("b_idle_no_start", obs_b, pk(0, 0, 0, 1, 0, 0, 0));
    b_bgn = 1'b1; b_mode_in = 1'b0;
    #1;
    chk("b_reaccept", obs_b, pk(1, 1, 0, 1, 0, 0, 0));
    @(negedge clk);
    b_bgn = 1'b0;
    #1;
    chk("b_exec_itr0", obs_b, pk(1, 0, 0, 0, 1, 0, 0));
    b_abort = 1'b1;
    #1;
    chk("b_abort_ld0", obs_b, pk(0, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    b_abort = 1'b0;
    #1;
    chk("b_abrt_pulse", obs_b, pk(0, 0, 0, 0, 0, 0, 1));

    // ---------------- short configuration (instance c) ----------------
    @(negedge clk);
    c_bgn = 1'b1; c_mode_in = 1'b0;
    #1;
    chk("c_accept", obs_c, pk(1, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      c_bgn = k[0];
      #1;
      chk($sformatf("c_exec_itr%0d", k), obs_c, pk(1, 0, k, 0, 1, 0, 0));
    end
    @(negedge clk);
    c_bgn = 1'b0;
    #1;
    chk("c_fin_cycle6", obs_c, pk(0, 0, 0, 0, 1, 1, 0));
    @(negedge clk);
    c_abort = 1'b1; c_ack = 1'b1;
    #1;
    chk("c_idle_abort_ack", obs_c, 12'h000);
    @(negedge clk);
    c_abort = 1'b0; c_ack = 1'b0;
    #1;
    chk("c_idle_unchanged", obs_c, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
